lock_sequencer: RTL and testbench

- Control FSM for the six-digit electronic lock datapath: one set-password register bank (3 digit-pair slots), one entered-password register bank (3 slots), one equality judge.
- Sequences digit-pair entry into the correct bank and slot, and fires the judge once per complete entry.
- Counts failed attempts, enforces a timed lockout, and drives the unlock/alarm outputs.
- Replaces manual slot-select inputs with a keyed strobe.

---
 rtl/lock_pkg.sv | 34 +++
 rtl/lock_timer.sv | 31 +++
 rtl/lock_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lock_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and helpers for the six-digit lock sequencer.
// Holds the FSM state enum, the slot width and the BCD digit checks.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET     = 3'd1,
    ENTRY   = 3'd2,
    JUDGE   = 3'd3,
    CHECK   = 3'd4,
    OPEN    = 3'd5,
    LOCKOUT = 3'd6
  } lock_state_e;

  localparam int                SLOT_W    = 2;
  localparam logic [3:0]        BCD_MAX   = 4'd9;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd2;

  function automatic logic digits_ok(input logic [3:0] a, input logic [3:0] b);
    return (a <= BCD_MAX) && (b <= BCD_MAX);
  endfunction

  function automatic logic [2:0] slot_onehot(input logic [SLOT_W-1:0] s);
    logic [2:0] oh;
    case (s)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag; it is shared by the lockout and
// auto-relock intervals of lock_sequencer.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_r;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Control FSM for the six-digit electronic lock: slot sequencing, judge strobe,
// failed-attempt count and lockout. Optional macro LOCK_AUTORELOCK_EN adds timed relock.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int OPEN_CYCLES = 500
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              m,
  input  logic              key_vld,
  input  logic [3:0]        inA,
  input  logic [3:0]        inB,
  input  logic              match,
  input  logic              relock,
  output logic [2:0]        set_we,
  output logic [2:0]        cin_we,
  output logic              cin_clr,
  output logic              judge_en,
  output logic              unlock,
  output logic              alarm,
  output logic              pw_set,
  output logic [3:0]        fail_cnt,
  output logic [SLOT_W-1:0] slot
);

  localparam int TMR_MAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  lock_state_e       state_r, state_s;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [3:0]        fail_cnt_r, fail_cnt_s, fail_inc_s;
  logic              pw_set_r, pw_set_s;
  logic              key_ok_s;
  logic [2:0]        set_we_s, cin_we_s;
  logic              cin_clr_s;
  logic              tmr_load_s, tmr_dec_s, tmr_done_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              unlock_r, alarm_r, judge_en_r;

  // Strobes are gated by clr so every output reads zero while reset is held.
  assign key_ok_s   = key_vld & ~clr & digits_ok(inA, inB);
  assign fail_inc_s = (fail_cnt_r == 4'd15) ? 4'd15 : (fail_cnt_r + 4'd1);

  // Next-state, slot/fail bookkeeping and combinational write strobes.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    fail_cnt_s = fail_cnt_r;
    pw_set_s   = pw_set_r;
    set_we_s   = 3'b000;
    cin_we_s   = 3'b000;
    cin_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_ok_s && !m) begin
          set_we_s = slot_onehot(slot_r);
          slot_s   = slot_r + 2'd1;
          state_s  = SET;
        end else if (key_ok_s && pw_set_r) begin
          cin_clr_s = 1'b1;
          slot_s    = 2'd0;
          state_s   = ENTRY;
        end else begin
          state_s = IDLE;
        end
      end
      SET: begin
        if (key_ok_s) begin
          set_we_s = slot_onehot(slot_r);
          if (slot_r == LAST_SLOT) begin
            pw_set_s   = 1'b1;
            fail_cnt_s = 4'd0;
            slot_s     = 2'd0;
            state_s    = IDLE;
          end else begin
            slot_s = slot_r + 2'd1;
          end
        end else begin
          state_s = SET;
        end
      end
      ENTRY: begin
        if (key_ok_s) begin
          cin_we_s = slot_onehot(slot_r);
          if (slot_r == LAST_SLOT) begin
            slot_s  = 2'd0;
            state_s = JUDGE;
          end else begin
            slot_s = slot_r + 2'd1;
          end
        end else begin
          state_s = ENTRY;
        end
      end
      JUDGE: begin
        state_s = CHECK;
      end
      CHECK: begin
        if (match) begin
          fail_cnt_s = 4'd0;
          state_s    = OPEN;
`ifdef LOCK_AUTORELOCK_EN
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(OPEN_CYCLES - 1);
`endif
        end else begin
          fail_cnt_s = fail_inc_s;
          if (fail_inc_s == 4'(MAX_FAIL)) begin
            tmr_load_s = 1'b1;
            tmr_val_s  = TMR_W'(LOCK_CYCLES - 1);
            state_s    = LOCKOUT;
          end else begin
            state_s = IDLE;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_s = IDLE;
`ifdef LOCK_AUTORELOCK_EN
        end else if (tmr_done_s) begin
          state_s = IDLE;
        end else begin
          tmr_dec_s = 1'b1;
`else
        end else begin
          state_s = OPEN;
`endif
        end
      end
      LOCKOUT: begin
        if (tmr_done_s) begin
          fail_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        slot_s  = 2'd0;
        state_s = IDLE;
      end
    endcase
  end

  // State and status registers; status outputs are registered from next state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= IDLE;
      slot_r     <= 2'd0;
      fail_cnt_r <= 4'd0;
      pw_set_r   <= 1'b0;
      unlock_r   <= 1'b0;
      alarm_r    <= 1'b0;
      judge_en_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      fail_cnt_r <= fail_cnt_s;
      pw_set_r   <= pw_set_s;
      unlock_r   <= (state_s == OPEN);
      alarm_r    <= (state_s == LOCKOUT);
      judge_en_r <= (state_s == JUDGE);
    end
  end

  lock_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .done     (tmr_done_s)
  );

  assign set_we   = set_we_s;
  assign cin_we   = cin_we_s;
  assign cin_clr  = cin_clr_s;
  assign judge_en = judge_en_r;
  assign unlock   = unlock_r;
  assign alarm    = alarm_r;
  assign pw_set   = pw_set_r;
  assign fail_cnt = fail_cnt_r;
  assign slot     = slot_r;

endmodule

// File: tb/tb_lock_sequencer.sv
// Randomised self-checking bench for lock_sequencer against a transaction-level
// model of the lock (password banks, entry progress, lockout/open intervals).
module tb_lock_sequencer;

  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int OPEN_CYCLES = 8;

  logic       clk, clr, m, key_vld, match, relock;
  logic [3:0] inA, inB;
  logic [2:0] set_we, cin_we;
  logic       cin_clr, judge_en, unlock, alarm, pw_set;
  logic [3:0] fail_cnt;
  logic [1:0] slot;

  lock_sequencer #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES),
    .OPEN_CYCLES (OPEN_CYCLES)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .m        (m),
    .key_vld  (key_vld),
    .inA      (inA),
    .inB      (inB),
    .match    (match),
    .relock   (relock),
    .set_we   (set_we),
    .cin_we   (cin_we),
    .cin_clr  (cin_clr),
    .judge_en (judge_en),
    .unlock   (unlock),
    .alarm    (alarm),
    .pw_set   (pw_set),
    .fail_cnt (fail_cnt),
    .slot     (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the lock is doing, in terms of pairs collected.
  bit         have_pw;
  int         fails, set_got, ent_got, judge_age, lock_left, open_left;
  bit         opened;
  logic [7:0] spw [3];
  logic [7:0] epw [3];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    return (set_got < 0) && (ent_got < 0) && (judge_age < 0) && !opened && (lock_left == 0);
  endfunction

  function automatic bit banks_equal();
    for (int i = 0; i < 3; i++) if (spw[i] != epw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    have_pw = 1'b0; fails = 0; set_got = -1; ent_got = -1;
    judge_age = -1; lock_left = 0; opened = 1'b0; open_left = 0;
  endtask

  task automatic check_outputs();
    bit kok;
    int exp_slot;
    logic [2:0] exp_set, exp_cin;
    bit exp_clr;
    kok = key_vld && (inA <= 4'd9) && (inB <= 4'd9) && !clr;
    exp_slot = (set_got >= 0) ? set_got : ((ent_got >= 0) ? ent_got : 0);
    exp_set = (kok && ((model_idle() && !m) || set_got >= 0)) ? 3'(1 << exp_slot) : 3'b000;
    exp_cin = (kok && ent_got >= 0) ? 3'(1 << exp_slot) : 3'b000;
    exp_clr = kok && model_idle() && m && have_pw;
    check_val("set_we",   32'(set_we),   32'(exp_set));
    check_val("cin_we",   32'(cin_we),   32'(exp_cin));
    check_val("cin_clr",  32'(cin_clr),  32'(exp_clr));
    check_val("judge_en", 32'(judge_en), 32'(judge_age == 0));
    check_val("unlock",   32'(unlock),   32'(opened));
    check_val("alarm",    32'(alarm),    32'(lock_left > 0));
    check_val("pw_set",   32'(pw_set),   32'(have_pw));
    check_val("fail_cnt", 32'(fail_cnt), 32'(fails));
    check_val("slot",     32'(slot),     32'(exp_slot));
  endtask

  task automatic model_step();
    bit kok;
    kok = key_vld && (inA <= 4'd9) && (inB <= 4'd9);
    if (model_idle()) begin
      if (kok && !m) begin
        spw[0] = {inA, inB};
        set_got = 1;
      end else if (kok && m && have_pw) begin
        for (int i = 0; i < 3; i++) epw[i] = 8'h00;
        ent_got = 0;
      end
    end else if (set_got >= 0) begin
      if (kok) begin
        spw[set_got] = {inA, inB};
        if (set_got == 2) begin set_got = -1; have_pw = 1'b1; fails = 0; end
        else set_got++;
      end
    end else if (ent_got >= 0) begin
      if (kok) begin
        epw[ent_got] = {inA, inB};
        if (ent_got == 2) begin ent_got = -1; judge_age = 0; end
        else ent_got++;
      end
    end else if (judge_age == 0) begin
      judge_age = 1;
    end else if (judge_age == 1) begin
      judge_age = -1;
      if (match) begin
        fails = 0; opened = 1'b1; open_left = OPEN_CYCLES;
      end else begin
        fails = (fails < 15) ? fails + 1 : 15;
        if (fails == MAX_FAIL) lock_left = LOCK_CYCLES;
      end
    end else if (opened) begin
      if (relock) opened = 1'b0;
`ifdef LOCK_AUTORELOCK_EN
      else begin
        open_left--;
        if (open_left == 0) opened = 1'b0;
      end
`endif
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end
  endtask

  // One clock: drive at low phase, check, then advance the model at the edge.
  task automatic step(input bit kv, input logic [3:0] a, input logic [3:0] b,
                      input bit mm, input bit rl);
    key_vld = kv; inA = a; inB = b; m = mm; relock = rl;
    match = (judge_age == 1) ? banks_equal() : 1'($urandom_range(0, 1));
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset(input bit kv);
    key_vld = kv; inA = 4'd1; inB = 4'd2; m = 1'b0; relock = 1'b0;
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic enter_pw(input logic [3:0] d);
    step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, d, d, 1'b1, 1'b0);
    step(1'b1, d, d, 1'b1, 1'b0);
    step(1'b1, d, d, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] a, b;
    for (int i = 0; i < 3; i++) begin spw[i] = 8'h00; epw[i] = 8'h00; end
    key_vld = 1'b0; inA = 4'd0; inB = 4'd0; m = 1'b0; match = 1'b0; relock = 1'b0;
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    apply_reset(1'b0);

    // Entry before any password: ignored.
    step(1'b1, 4'd1, 4'd2, 1'b1, 1'b0);
    idle_cycles(2);

    // Set 12/34/56 then enter it correctly.
    step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 4'd3, 4'd4, 1'b1, 1'b0);
    step(1'b1, 4'd5, 4'd6, 1'b1, 1'b0);
    idle_cycles(1);
    step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 4'd2, 1'b1, 1'b0);
    step(1'b1, 4'hA, 4'd2, 1'b1, 1'b0);
    step(1'b1, 4'd3, 4'd4, 1'b1, 1'b0);
    step(1'b1, 4'd5, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'd5, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < OPEN_CYCLES + 4; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
    idle_cycles(1);

    // Three wrong entries: lockout, keys ignored throughout.
    for (int k = 0; k < MAX_FAIL; k++) begin
      enter_pw(4'd7);
      idle_cycles(2);
    end
    for (int i = 0; i < LOCK_CYCLES + 3; i++)
      step(1'b1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of an entry.
    step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 4'd2, 1'b1, 1'b0);
    step(1'b1, 4'd3, 4'd4, 1'b1, 1'b0);
    apply_reset(1'b1);
    idle_cycles(1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset(1'($urandom_range(0, 1)));
      end else begin
        a = 4'($urandom_range(0, 9));
        b = 4'($urandom_range(0, 9));
        if (ent_got >= 0 && $urandom_range(0, 3) != 0) begin
          a = spw[ent_got][7:4];
          b = spw[ent_got][3:0];
        end
        if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(10, 15));
        if ($urandom_range(0, 9) == 0) b = 4'($urandom_range(10, 15));
        step(1'($urandom_range(0, 1)), a, b, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
